// File: rtl/fb_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_sched
// Purpose  : Framebuffer write scheduler. Merges random-access host pixel
//            writes with a hardware full-frame fill engine onto a single
//            registered framebuffer write port. During a fill, host and fill
//            share the port round-robin; outside a fill the host owns it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W            framebuffer write-address width
//   DATA_W            pixel width, packed {R, G, B}
//   FILL_TOTAL_SHIFT  right shift applied to the fill pixel totals; 0 in
//                     silicon, a positive value shortens fills for bring-up
//                     and simulation (must keep both totals non-zero)
// Ports
//   clk          in   pixel clock, rising edge
//   rst          in   synchronous reset, active low
//   res          in   resolution select: 2'b01 = 1280x720, else 640x480
//   host_valid   in   host pixel write request
//   host_ready   out  host write accepted when host_valid is also high
//   host_x/y     in   host pixel column / row
//   host_data    in   host pixel value
//   fill_start   in   single-cycle pulse, starts a full-frame fill
//   fill_color   in   fill value, sampled with an accepted fill_start
//   fill_busy    out  fill in progress (FILL or DONE)
//   fill_done    out  one-cycle pulse alongside the last fill write
//   oob_err      out  one-cycle pulse after an out-of-bounds host write
//   vram_we      out  framebuffer write enable (registered)
//   vram_addr    out  framebuffer write address (registered, held)
//   vram_data    out  framebuffer write data (registered, held)
// ============================================================================
module fb_write_sched #(
    parameter int ADDR_W           = 20,
    parameter int DATA_W           = 24,
    parameter int FILL_TOTAL_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        res,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [11:0]       host_x,
    input  logic [11:0]       host_y,
    input  logic [DATA_W-1:0] host_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              oob_err,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data
);

    // Fill counter width: wide enough for the 1280x720 pixel count.
    localparam int c_CNT_W = 20;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FILL = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [c_CNT_W-1:0] c_TOTAL_HD = c_CNT_W'(921600 >> FILL_TOTAL_SHIFT);
    localparam logic [c_CNT_W-1:0] c_TOTAL_SD = c_CNT_W'(307200 >> FILL_TOTAL_SHIFT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_total;
    logic [DATA_W-1:0]  r_color;
    logic               r_rr_fill;   // 1 = most recent grant went to the fill engine
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_oob;

    logic               w_in_fill;
    logic               w_ready;
    logic               w_host_grant;
    logic               w_fill_grant;
    logic               w_hd;
    logic [11:0]        w_width;
    logic [11:0]        w_height;
    logic               w_in_bounds;
    logic [23:0]        w_host_lin;
    logic [ADDR_W-1:0]  w_host_addr;
    logic               w_fill_last;

    // ------------------------------------------------------------------------
    // Arbitration. host_ready is a function of state and the round-robin bit
    // only, so the host may legally wait on it before raising host_valid.
    // Outside FILL (including the single DONE cycle) the host owns the port.
    // ------------------------------------------------------------------------
    assign w_in_fill    = (r_state == c_ST_FILL);
    assign w_ready      = rst & (~w_in_fill | r_rr_fill);
    assign w_host_grant = host_valid & w_ready;
    // Fill takes every FILL cycle the host does not win, including cycles
    // where host_ready is high but the host has nothing to write.
    assign w_fill_grant = w_in_fill & ~w_host_grant;

    // ------------------------------------------------------------------------
    // Host address generation, bounds taken from res on the acceptance cycle.
    // ------------------------------------------------------------------------
    assign w_hd        = (res == 2'b01);
    assign w_width     = w_hd ? 12'd1280 : 12'd640;
    assign w_height    = w_hd ? 12'd720  : 12'd480;
    assign w_in_bounds = (host_x < w_width) && (host_y < w_height);
    assign w_host_lin  = 24'(host_y) * 24'(w_width) + 24'(host_x);
    assign w_host_addr = ADDR_W'(w_host_lin);

    assign w_fill_last = (r_cnt == (r_total - c_CNT_ONE));

    // ------------------------------------------------------------------------
    // Registered write port, round-robin bit and fill FSM.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_total   <= '0;
            r_color   <= '0;
            r_rr_fill <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_oob     <= 1'b0;
        end else begin
            // One write per grant, visible the following cycle. An
            // out-of-bounds host write is consumed but only flags oob_err.
            r_we  <= w_fill_grant | (w_host_grant & w_in_bounds);
            r_oob <= w_host_grant & ~w_in_bounds;

            // Address/data only move on a real write so they hold otherwise.
            if (w_fill_grant) begin
                r_addr <= ADDR_W'(r_cnt);
                r_data <= r_color;
            end else if (w_host_grant && w_in_bounds) begin
                r_addr <= w_host_addr;
                r_data <= host_data;
            end

            if (w_fill_grant) begin
                r_rr_fill <= 1'b1;
            end else if (w_host_grant) begin
                r_rr_fill <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    // Total and colour are latched here so later changes to
                    // res or fill_color cannot disturb a running fill.
                    if (fill_start) begin
                        r_total <= w_hd ? c_TOTAL_HD : c_TOTAL_SD;
                        r_color <= fill_color;
                        r_cnt   <= '0;
                        r_state <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (w_fill_grant) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_fill_last) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign host_ready = w_ready;
    assign fill_busy  = (r_state == c_ST_FILL) || (r_state == c_ST_DONE);
    // DONE coincides with the registered write of the last fill pixel.
    assign fill_done  = (r_state == c_ST_DONE);
    assign oob_err    = r_oob;
    assign vram_we    = r_we;
    assign vram_addr  = r_addr;
    assign vram_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_sched
// Purpose  : Self-checking bench for fb_write_sched: a table of idle host
//            writes, hand-written fill sequences and randomised traffic, all
//            checked cycle by cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_sched;

    localparam int SHIFT  = 12;
    localparam int TOT_SD = 307200 >> SHIFT;   // 75
    localparam int TOT_HD = 921600 >> SHIFT;   // 225

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  res;
    logic        host_valid;
    logic        host_ready;
    logic [11:0] host_x;
    logic [11:0] host_y;
    logic [23:0] host_data;
    logic        fill_start;
    logic [23:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        oob_err;
    logic        vram_we;
    logic [19:0] vram_addr;
    logic [23:0] vram_data;

    always #5 clk = ~clk;

    fb_write_sched #(
        .ADDR_W(20), .DATA_W(24), .FILL_TOTAL_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .res(res),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_x(host_x), .host_y(host_y), .host_data(host_data),
        .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done), .oob_err(oob_err),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_busy      = 0;   // a fill is running or in its done cycle
    bit          m_done      = 0;   // the done cycle
    bit          m_last_fill = 0;   // last port grant went to fill
    int          m_next      = 0;   // next fill pixel index
    int          m_total     = 0;
    logic [23:0] m_color     = '0;
    bit          m_we        = 0;
    bit          m_oob       = 0;
    logic [19:0] m_addr      = '0;
    logic [23:0] m_data      = '0;

    // One clock: inputs are already set; check host_ready mid-cycle, advance
    // the model, then check registered outputs just after the rising edge.
    task automatic step();
        bit running, exp_ready, host_go, fill_go, inb, start_ok;
        int w, h;
        @(negedge clk);
        running   = m_busy && !m_done;
        exp_ready = rst && (!running || m_last_fill);
        chk("host_ready", 32'(host_ready), 32'(exp_ready));
        if (!rst) begin
            m_busy = 0; m_done = 0; m_last_fill = 0; m_next = 0;
            m_we = 0; m_oob = 0; m_addr = '0; m_data = '0;
        end else begin
            w        = (res == 2'b01) ? 1280 : 640;
            h        = (res == 2'b01) ? 720 : 480;
            inb      = (int'(host_x) < w) && (int'(host_y) < h);
            host_go  = host_valid && exp_ready;
            fill_go  = running && !host_go;
            start_ok = !m_busy;
            m_we     = fill_go || (host_go && inb);
            m_oob    = host_go && !inb;
            if (fill_go) begin
                m_addr = 20'(m_next);
                m_data = m_color;
            end else if (host_go && inb) begin
                m_addr = 20'(int'(host_y) * w + int'(host_x));
                m_data = host_data;
            end
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end
            if (fill_go) begin
                m_last_fill = 1;
                m_next++;
                if (m_next == m_total) m_done = 1;
            end else if (host_go) begin
                m_last_fill = 0;
            end
            if (start_ok && fill_start) begin
                m_busy  = 1;
                m_total = (res == 2'b01) ? TOT_HD : TOT_SD;
                m_color = fill_color;
                m_next  = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("vram_we",   32'(vram_we),   32'(m_we));
        chk("vram_addr", 32'(vram_addr), 32'(m_addr));
        chk("vram_data", 32'(vram_data), 32'(m_data));
        chk("oob_err",   32'(oob_err),   32'(m_oob));
        chk("fill_busy", 32'(fill_busy), 32'(m_busy));
        chk("fill_done", 32'(fill_done), 32'(m_done));
    endtask

    task automatic quiet();
        host_valid = 1'b0;
        fill_start = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  res;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] d;
        logic        exp_we;
        logic [19:0] exp_addr;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nw, nd, bad, done_at, busy_low_at, nf, nh, alt_bad, fidx, prev_fill, first_kind;
        rst = 1'b0; res = 2'b00; host_valid = 1'b0; host_x = '0; host_y = '0;
        host_data = '0; fill_start = 1'b0; fill_color = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("reset_we",   32'(vram_we),   32'd0);
        chk("reset_addr", 32'(vram_addr), 32'd0);
        chk("reset_busy", 32'(fill_busy), 32'd0);
        rst = 1'b1;

        // ---------------- idle host-write table ----------------
        vecs[0] = '{2'd0, 12'd10,   12'd2,   24'hFF0000, 1'b1, 20'd1290,   1'b0};
        vecs[1] = '{2'd1, 12'd5,    12'd3,   24'h00FF00, 1'b1, 20'd3845,   1'b0};
        vecs[2] = '{2'd0, 12'd639,  12'd479, 24'h0000FF, 1'b1, 20'd307199, 1'b0};
        vecs[3] = '{2'd1, 12'd1279, 12'd719, 24'h123456, 1'b1, 20'd921599, 1'b0};
        vecs[4] = '{2'd1, 12'd700,  12'd500, 24'hABCDEF, 1'b1, 20'd640700, 1'b0};
        vecs[5] = '{2'd0, 12'd640,  12'd0,   24'h111111, 1'b0, 20'd0,      1'b1};
        vecs[6] = '{2'd0, 12'd0,    12'd480, 24'h222222, 1'b0, 20'd0,      1'b1};
        vecs[7] = '{2'd1, 12'd1280, 12'd5,   24'h333333, 1'b0, 20'd0,      1'b1};
        vecs[8] = '{2'd2, 12'd700,  12'd10,  24'h444444, 1'b0, 20'd0,      1'b1};
        vecs[9] = '{2'd3, 12'd100,  12'd479, 24'h555555, 1'b1, 20'd306660, 1'b0};
        for (int i = 0; i < 10; i++) begin
            res = vecs[i].res; host_x = vecs[i].x; host_y = vecs[i].y;
            host_data = vecs[i].d; host_valid = 1'b1;
            step();
            chk("tbl_we",  32'(vram_we), 32'(vecs[i].exp_we));
            chk("tbl_oob", 32'(oob_err), 32'(vecs[i].exp_oob));
            if (vecs[i].exp_we) begin
                chk("tbl_addr", 32'(vram_addr), 32'(vecs[i].exp_addr));
                chk("tbl_data", 32'(vram_data), 32'(vecs[i].d));
            end
            host_valid = 1'b0;
            step();
            chk("tbl_we_drop", 32'(vram_we), 32'd0);
            chk("tbl_oob_drop", 32'(oob_err), 32'd0);
        end

        // ---------------- A: uncontended fill, 640x480 ----------------
        do_reset();
        res = 2'b00; fill_color = 24'h000000; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        nw = 0; nd = 0; bad = 0; done_at = -1; busy_low_at = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (vram_we) begin
                if (vram_addr != 20'(nw)) bad++;
                nw++;
            end
            if (fill_done) begin nd++; done_at = i; end
            if (!fill_busy) begin busy_low_at = i; break; end
        end
        chk("A_writes", 32'(nw), 32'(TOT_SD));
        chk("A_contig", 32'(bad), 32'd0);
        chk("A_done_cnt", 32'(nd), 32'd1);
        chk("A_busy_fall", 32'(busy_low_at - done_at), 32'd1);

        // ---------------- B: contended fill, 1280x720 ----------------
        do_reset();
        res = 2'b01; fill_color = 24'h00FF00; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        host_valid = 1'b1; host_x = 12'd3; host_y = 12'd4; host_data = 24'h0000AA;
        nf = 0; nh = 0; alt_bad = 0; fidx = 0; prev_fill = -1; first_kind = -1; bad = 0; nd = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (vram_we) begin
                if (vram_data == 24'h00FF00) begin
                    if (vram_addr != 20'(fidx)) bad++;
                    fidx++; nf++;
                    if (first_kind < 0) first_kind = 1;
                    if (prev_fill == 1) alt_bad++;
                    prev_fill = 1;
                end else begin
                    if (vram_addr != 20'd5123) bad++;
                    nh++;
                    if (first_kind < 0) first_kind = 0;
                    if (prev_fill == 0) alt_bad++;
                    prev_fill = 0;
                end
            end
            if (fill_done) begin nd++; break; end
        end
        host_valid = 1'b0;
        step();
        chk("B_first_fill", 32'(first_kind), 32'd1);
        chk("B_alternate", 32'(alt_bad), 32'd0);
        chk("B_fills", 32'(nf), 32'(TOT_HD));
        chk("B_hosts", 32'(nh), 32'(TOT_HD - 1));
        chk("B_granted", 32'(nf + nh), 32'(2 * TOT_HD - 1));
        chk("B_addr", 32'(bad), 32'd0);
        chk("B_done", 32'(nd), 32'd1);

        // ---------------- C: restart and res change ignored mid-fill ----------------
        res = 2'b00; fill_color = 24'hAAAAAA; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        nf = 0; bad = 0; nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 10) begin
                fill_start = 1'b1; fill_color = 24'h123456; res = 2'b01;
            end else begin
                fill_start = 1'b0;
            end
            step();
            if (vram_we) begin
                if (vram_data != 24'hAAAAAA) bad++;
                nf++;
            end
            if (fill_done) nd++;
            if (!fill_busy) break;
        end
        chk("C_total", 32'(nf), 32'(TOT_SD));
        chk("C_color", 32'(bad), 32'd0);
        chk("C_done", 32'(nd), 32'd1);

        // ---------------- D: reset mid-fill at counter 100 ----------------
        quiet();
        res = 2'b01; fill_color = 24'h0F0F0F; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fill_done) nd++;
        end
        chk("D_last_addr", 32'(vram_addr), 32'd99);
        rst = 1'b0;
        step();
        if (fill_done) nd++;
        chk("D_rst_we", 32'(vram_we), 32'd0);
        chk("D_rst_addr", 32'(vram_addr), 32'd0);
        chk("D_rst_data", 32'(vram_data), 32'd0);
        chk("D_rst_busy", 32'(fill_busy), 32'd0);
        rst = 1'b1;
        step();
        if (fill_done) nd++;
        chk("D_no_done", 32'(nd), 32'd0);
        fill_color = 24'h777777; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        chk("D_restart_we", 32'(vram_we), 32'd1);
        chk("D_restart_addr", 32'(vram_addr), 32'd0);
        chk("D_restart_data", 32'(vram_data), 32'h777777);
        for (int i = 0; i < 300 && fill_busy; i++) step();
        chk("D_finished", 32'(fill_busy), 32'd0);

        // ---------------- randomised traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) != 0);
            res        = 2'($urandom_range(0, 3));
            host_valid = 1'($urandom_range(0, 1));
            host_x     = 12'($urandom_range(0, 1300));
            host_y     = 12'($urandom_range(0, 740));
            host_data  = 24'($urandom);
            fill_start = ($urandom_range(0, 24) == 0);
            fill_color = 24'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
